// File: rtl/dds_hop_pkg.sv
// Shared types and default constants for the LFSR-driven frequency-hop controller.
package dds_hop_pkg;

  // Hop controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    CALC  = 2'd2,
    OFFER = 2'd3
  } hop_state_e;

  // Width of the upstream LFSR state
  localparam int LFSR_W = 5;

  // Default tuning-word and dwell configuration
  localparam int          DEF_TW_W    = 32;
  localparam int          DEF_DWELL_W = 16;
  localparam logic [31:0] DEF_BASE_TW = 32'h0100_0000;
  localparam logic [31:0] DEF_STEP_TW = 32'h0001_0000;

endpackage

// File: rtl/hop_dwell_timer.sv
// Down-counter that times one dwell interval; the FSM loads it and asks it to count.
module hop_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [DWELL_W-1:0] cnt_r;

  // Load on interval start, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/lfsr_hop_ctrl.sv
// Frequency-hop controller: samples the LFSR once per dwell interval, maps it to
// a DDS tuning word BASE_TW + lfsr * STEP_TW and offers it over valid/ready.
// Optional accepted-hop counter port hop_count is built when HOP_CNT_EN is defined.
module lfsr_hop_ctrl
  import dds_hop_pkg::*;
#(
  parameter int              TW_W    = DEF_TW_W,
  parameter int              DWELL_W = DEF_DWELL_W,
  parameter logic [TW_W-1:0] BASE_TW = DEF_BASE_TW,
  parameter logic [TW_W-1:0] STEP_TW = DEF_STEP_TW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LFSR_W-1:0]  lfsr,
  output logic [TW_W-1:0]    tw_data,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic               busy,
  output logic               lock_err
`ifdef HOP_CNT_EN
  ,
  output logic [15:0]        hop_count
`endif
);

  localparam logic [DWELL_W-1:0] DW_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  hop_state_e          state_r;
  logic [LFSR_W-1:0]   lfsr_r;
  logic                load_s;
  logic                dec_s;
  logic                zero_s;
  logic [DWELL_W-1:0]  load_val_s;
  logic [TW_W-1:0]     prod_s;
  logic [TW_W-1:0]     tw_calc_s;

  // Dwell timer control: reload on every interval start, count while dwelling
  always_comb begin
    load_s = 1'b0;
    dec_s  = 1'b0;
    case (state_r)
      IDLE:    load_s = en;
      DWELL:   dec_s  = 1'b1;
      OFFER:   load_s = tw_ready & en;
      default: begin
        load_s = 1'b0;
        dec_s  = 1'b0;
      end
    endcase
    // A dwell of 0 behaves as 1, so the load value never underflows
    if (dwell == DW_ZERO) begin
      load_val_s = DW_ZERO;
    end else begin
      load_val_s = dwell - DW_ONE;
    end
  end

  // Tuning-word arithmetic from the registered LFSR sample, truncated and wrapping
  always_comb begin
    prod_s    = STEP_TW * {{(TW_W-LFSR_W){1'b0}}, lfsr_r};
    tw_calc_s = BASE_TW + prod_s;
  end

  hop_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .zero     (zero_s)
  );

  // Hop FSM with registered handshake, status and tuning-word outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      lfsr_r   <= {LFSR_W{1'b0}};
      tw_data  <= {TW_W{1'b0}};
      tw_valid <= 1'b0;
      busy     <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) begin
            state_r <= DWELL;
            busy    <= 1'b1;
          end
        end
        DWELL: begin
          if (!en) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (zero_s) begin
            state_r <= CALC;
            lfsr_r  <= lfsr;
          end
        end
        CALC: begin
          tw_data  <= tw_calc_s;
          tw_valid <= 1'b1;
          state_r  <= OFFER;
          // All-zero LFSR is a lock-up: flag it but still emit the word
          if (lfsr_r == {LFSR_W{1'b0}}) begin
            lock_err <= 1'b1;
          end
        end
        OFFER: begin
          // The offer is never retracted; only a handshake ends it
          if (tw_ready) begin
            tw_valid <= 1'b0;
            if (en) begin
              state_r <= DWELL;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          tw_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef HOP_CNT_EN
  // Count accepted hops, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hop_count <= 16'h0000;
    end else if ((state_r == OFFER) && tw_valid && tw_ready) begin
      hop_count <= hop_count + 16'h0001;
    end else begin
      hop_count <= hop_count;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_hop_ctrl.sv
// Self-checking bench for lfsr_hop_ctrl (two instances: default base and wrapping base).
module tb_lfsr_hop_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] dwell = 16'd0;
  logic [4:0]  lfsr = 5'd0;
  logic        tw_ready = 1'b0;
  logic [31:0] tw_data, w_tw_data;
  logic        tw_valid, w_tw_valid;
  logic        busy, w_busy;
  logic        lock_err, w_lock_err;
`ifdef HOP_CNT_EN
  logic [15:0] hop_count, w_hop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_hop_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .dwell(dwell), .lfsr(lfsr),
    .tw_data(tw_data), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .busy(busy), .lock_err(lock_err)
`ifdef HOP_CNT_EN
    , .hop_count(hop_count)
`endif
  );

  lfsr_hop_ctrl #(.BASE_TW(32'hFFFF_0000)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dwell(dwell), .lfsr(lfsr),
    .tw_data(w_tw_data), .tw_valid(w_tw_valid), .tw_ready(tw_ready),
    .busy(w_busy), .lock_err(w_lock_err)
`ifdef HOP_CNT_EN
    , .hop_count(w_hop_count)
`endif
  );

  // Reference mapping: base + lfsr * step, modulo 2^32
  function automatic logic [31:0] exp_tw(input logic [31:0] base, input int l);
    logic [63:0] s;
    s = {32'd0, base} + 64'(l) * 64'h0000_0000_0001_0000;
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a hop whose interval begins on the next edge; drive the target LFSR value
  // only in the last dwell cycle. Returns cycles from that edge until tw_valid (-1 on timeout).
  task automatic run_hop(input int d, input logic [4:0] target, output int cycles);
    int deff;
    int k;
    deff   = (d == 0) ? 1 : d;
    dwell  = d[15:0];
    en     = 1'b1;
    cycles = -1;
    k      = 0;
    lfsr   = target ^ 5'($urandom_range(1, 31));
    while (k < deff + 20) begin
      tick();
      k++;
      if (tw_valid) begin
        cycles = k;
        break;
      end
      if (k == 1) dwell = 16'($urandom_range(0, 9));
      if (k == deff) lfsr = target;
      else lfsr = target ^ 5'($urandom_range(1, 31));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en = 1'b0;
    tw_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic go_idle();
    en = 1'b0;
    tw_ready = 1'b1;
    repeat (3) tick();
    tw_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (tw_data !== 32'd0) begin n_bad++; $display("FAIL reset_tw_data got %h want 00000000", tw_data); end
    n_cmp++; if (tw_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tw_valid got %b want 0", tw_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (lock_err !== 1'b0) begin n_bad++; $display("FAIL reset_lock_err got %b want 0", lock_err); end
  endtask

  task automatic test_single_hop();
    int c;
    tw_ready = 1'b1;
    run_hop(4, 5'h13, c);
    n_cmp++; if (c !== 6) begin n_bad++; $display("FAIL single_latency got %0d want 6", c); end
    n_cmp++; if (tw_data !== 32'h0113_0000) begin n_bad++; $display("FAIL single_tw_data got %h want 01130000", tw_data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
    en = 1'b0;
    tick();
    n_cmp++; if (tw_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle_valid got %b want 0", tw_valid); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int c;
    int d;
    logic [4:0] t;
    tw_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 7);
      t = 5'($urandom_range(1, 31));
      run_hop(d, t, c);
      n_cmp++; if (c !== ((d == 0) ? 1 : d) + 2) begin n_bad++; $display("FAIL b2b_period[%0d] got %0d want %0d", i, c, ((d == 0) ? 1 : d) + 2); end
      n_cmp++; if (tw_data !== exp_tw(32'h0100_0000, int'(t))) begin n_bad++; $display("FAIL b2b_tw_data[%0d] got %h want %h", i, tw_data, exp_tw(32'h0100_0000, int'(t))); end
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    int c;
    int held_bad;
    tw_ready = 1'b0;
    run_hop(3, 5'h0A, c);
    n_cmp++; if (c !== 5) begin n_bad++; $display("FAIL bp_latency got %0d want 5", c); end
    held_bad = 0;
    for (int i = 0; i < 6; i++) begin
      lfsr = 5'($urandom_range(1, 31));
      tick();
      if (tw_valid !== 1'b1 || tw_data !== 32'h010A_0000) held_bad++;
    end
    n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", held_bad); end
    tw_ready = 1'b1;
    run_hop(2, 5'h15, c);
    n_cmp++; if (c !== 4) begin n_bad++; $display("FAIL bp_next_interval got %0d want 4", c); end
    n_cmp++; if (tw_data !== 32'h0115_0000) begin n_bad++; $display("FAIL bp_next_tw_data got %h want 01150000", tw_data); end
    go_idle();
  endtask

  task automatic test_disable_dwell();
    int seen;
    dwell = 16'd5;
    en = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dis_dwell_busy got %b want 1", busy); end
    en = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dis_dwell_idle got %b want 0", busy); end
    seen = 0;
    repeat (8) begin
      tick();
      if (tw_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL dis_dwell_no_offer got %0d want 0", seen); end
  endtask

  task automatic test_disable_offer();
    int c;
    int drop;
    tw_ready = 1'b0;
    run_hop(2, 5'h09, c);
    en = 1'b0;
    drop = 0;
    repeat (3) begin
      tick();
      if (tw_valid !== 1'b1 || tw_data !== 32'h0109_0000) drop++;
    end
    n_cmp++; if (drop !== 0) begin n_bad++; $display("FAIL dis_offer_held got %0d want 0", drop); end
    tw_ready = 1'b1;
    tick();
    n_cmp++; if ({tw_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL dis_offer_done got %b want 00", {tw_valid, busy}); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dis_offer_idle got %b want 0", busy); end
    tw_ready = 1'b0;
  endtask

  task automatic test_dwell_zero();
    int c;
    tw_ready = 1'b1;
    run_hop(0, 5'h02, c);
    run_hop(0, 5'h03, c);
    n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL dwell0_period got %0d want 3", c); end
    n_cmp++; if (tw_data !== 32'h0103_0000) begin n_bad++; $display("FAIL dwell0_tw_data got %h want 01030000", tw_data); end
    go_idle();
  endtask

  task automatic test_wrap();
    int c;
    tw_ready = 1'b0;
    run_hop(2, 5'h1F, c);
    n_cmp++; if (w_tw_data !== 32'h001E_0000) begin n_bad++; $display("FAIL wrap_tw_data got %h want 001e0000", w_tw_data); end
    n_cmp++; if (tw_data !== 32'h011F_0000) begin n_bad++; $display("FAIL wrap_ref_tw_data got %h want 011f0000", tw_data); end
    go_idle();
  endtask

  task automatic test_lockup();
    int c;
    n_cmp++; if (lock_err !== 1'b0) begin n_bad++; $display("FAIL lock_pre got %b want 0", lock_err); end
    tw_ready = 1'b1;
    run_hop(3, 5'h00, c);
    n_cmp++; if (tw_data !== 32'h0100_0000) begin n_bad++; $display("FAIL lock_tw_data got %h want 01000000", tw_data); end
    n_cmp++; if (lock_err !== 1'b1) begin n_bad++; $display("FAIL lock_set got %b want 1", lock_err); end
    run_hop(2, 5'h11, c);
    run_hop(1, 5'h05, c);
    n_cmp++; if (lock_err !== 1'b1) begin n_bad++; $display("FAIL lock_sticky got %b want 1", lock_err); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    int c;
    tw_ready = 1'b0;
    run_hop(3, 5'h07, c);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (tw_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_tw_valid got %b want 0", tw_valid); end
    n_cmp++; if ({tw_data, busy, lock_err} !== 34'd0) begin n_bad++; $display("FAIL rstmid_outputs got %h want 0", {tw_data, busy, lock_err}); end
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({tw_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rstmid_after got %b want 00", {tw_valid, busy}); end
  endtask

  task automatic test_random();
    int c;
    int d;
    int s;
    int held_bad;
    logic [4:0] t;
    logic seen_zero;
    logic [31:0] e;
    seen_zero = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = $urandom_range(0, 7);
      s = $urandom_range(0, 3);
      t = 5'($urandom_range(0, 31));
      run_hop(d, t, c);
      if (t == 5'd0) seen_zero = 1'b1;
      e = exp_tw(32'h0100_0000, int'(t));
      n_cmp++; if (c !== ((d == 0) ? 1 : d) + 2) begin n_bad++; $display("FAIL rnd_period[%0d] got %0d want %0d", i, c, ((d == 0) ? 1 : d) + 2); end
      n_cmp++; if (tw_data !== e || w_tw_data !== exp_tw(32'hFFFF_0000, int'(t))) begin n_bad++; $display("FAIL rnd_tw_data[%0d] got %h/%h want %h/%h", i, tw_data, w_tw_data, e, exp_tw(32'hFFFF_0000, int'(t))); end
      n_cmp++; if (lock_err !== seen_zero) begin n_bad++; $display("FAIL rnd_lock_err[%0d] got %b want %b", i, lock_err, seen_zero); end
      tw_ready = 1'b0;
      held_bad = 0;
      for (int j = 0; j < s; j++) begin
        lfsr = 5'($urandom_range(0, 31));
        tick();
        if (tw_valid !== 1'b1 || tw_data !== e) held_bad++;
      end
      n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL rnd_stall_hold[%0d] got %0d want 0", i, held_bad); end
      tw_ready = 1'b1;
    end
    go_idle();
  endtask

`ifdef HOP_CNT_EN
  task automatic test_hop_count();
    int c;
    apply_reset();
    n_cmp++; if (hop_count !== 16'd0) begin n_bad++; $display("FAIL cnt_reset got %h want 0000", hop_count); end
    tw_ready = 1'b1;
    run_hop(2, 5'h01, c);
    run_hop(1, 5'h02, c);
    run_hop(3, 5'h03, c);
    en = 1'b0;
    tick();
    tick();
    n_cmp++; if (hop_count !== 16'd3) begin n_bad++; $display("FAIL cnt_three got %h want 0003", hop_count); end
    force u_dut.hop_count = 16'hFFFF;
    tick();
    release u_dut.hop_count;
    tick();
    run_hop(1, 5'h04, c);
    en = 1'b0;
    tick();
    tick();
    n_cmp++; if (hop_count !== 16'd0) begin n_bad++; $display("FAIL cnt_wrap got %h want 0000", hop_count); end
    tw_ready = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hop();
    test_back_to_back();
    test_backpressure();
    test_disable_dwell();
    test_disable_offer();
    test_dwell_zero();
    test_wrap();
    test_lockup();
    test_reset_mid();
    test_random();
`ifdef HOP_CNT_EN
    test_hop_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_hop_ctrl.md
# lfsr_hop_ctrl

Frequency-hop controller sitting directly downstream of the 5-bit LFSR. It samples the LFSR state once per programmable dwell interval and maps it to a DDS tuning word as BASE_TW + lfsr × STEP_TW. It offers the word to the DDS phase-accumulator stage over a valid/ready handshake. It also flags the all-zero LFSR lock-up state.

## Interface
- TW_W, 32, tuning-word width
- DWELL_W, 16, dwell-count width
- BASE_TW, 32'h0100_0000, tuning word for lfsr = 0
- STEP_TW, 32'h0001_0000, tuning-word increment per LFSR count
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- en  in  1  hop enable, level
- dwell  in  DWELL_W  cycles per dwell; 0 is treated as 1
- lfsr  in  5  LFSR state, sampled only at the DWELL→CALC edge
- tw_data  out  TW_W  tuning word; stable while tw_valid = 1
- tw_valid  out  1  tuning word offered
- tw_ready  in  1  downstream accepts
- busy  out  1  state ≠ IDLE
- lock_err  out  1  sticky; set when a sampled lfsr = 0
- hop_count  out  16  accepted-hop counter (only with HOP_CNT_EN)

## Operation
- FSM states: IDLE, DWELL, CALC, OFFER.
- IDLE:
  - en = 1 → DWELL.
  - The dwell counter loads max(dwell,1) − 1 on this transition.
- DWELL:
  - Counter decrements each cycle.
  - en = 0 → IDLE next cycle; no sample is taken.
  - Counter = 0 and en = 1 → CALC, and lfsr is registered on that edge.
- CALC:
  - tw_data ← (BASE_TW + lfsr_q × STEP_TW) mod 2^TW_W.
  - lfsr_q = 0 → lock_err ← 1; the word is still produced.
  - Always → OFFER.
- OFFER:
  - tw_valid = 1.
  - tw_valid never drops and tw_data never changes until tw_valid & tw_ready; en = 0 does not retract the offer.
  - On handshake: en = 1 → DWELL (counter reloads dwell); en = 0 → IDLE.
- dwell is sampled only at counter load; changes mid-dwell take effect on the next interval.
- lock_err clears only on reset.

## Timing
- Reset values (asserted asynchronously, released synchronously):
  - state = IDLE, tw_data = 0, tw_valid = 0, busy = 0, lock_err = 0, counter = 0, hop_count = 0.
- Let en be sampled high in IDLE at edge N, with D = max(dwell,1):
  - DWELL spans cycles N+1 … N+D.
  - lfsr is sampled at the edge ending cycle N+D.
  - CALC occurs in cycle N+D+1.
  - tw_valid = 1 from cycle N+D+2.
- With tw_ready held high, hop period = D + 2 cycles.
- Stall: each cycle with tw_ready = 0 in OFFER extends the period by 1.
- tw_ready is ignored outside OFFER.
- Reset asserted mid-operation: tw_valid drops immediately and the pending word is discarded.
- Multiply: 5-bit × TW_W result truncated to TW_W bits, then added with wrap. Registered in CALC; no combinational path from lfsr to tw_data.

## Configuration
- HOP_CNT_EN defined:
  - hop_count increments by 1 on each tw_valid & tw_ready.
  - Wraps 16'hFFFF → 0.
  - Reset value 0.
- Not defined: hop_count port and counter are absent; all other behaviour is identical.

## Structure
- Package dds_hop_pkg holds:
  - state enum (IDLE, DWELL, CALC, OFFER)
  - LFSR_W = 5
  - default TW_W / DWELL_W / BASE_TW / STEP_TW constants
- Sub-module hop_dwell_timer (inputs: load, load value, decrement; output: zero flag). The FSM, arithmetic and handshake stay in lfsr_hop_ctrl.

## Test plan
- Single hop:
  - Stimulus: dwell = 4, lfsr = 5'h13 at the sample edge, tw_ready = 1, en pulsed high then held.
  - Response: tw_valid high exactly 6 cycles after en is sampled; tw_data = 32'h0113_0000; one-cycle valid.
- Backpressure:
  - Stimulus: tw_ready = 0 for 7 cycles during OFFER, and lfsr changes meanwhile.
  - Response: tw_valid and tw_data held constant; handshake on cycle 8; next DWELL starts the following cycle.
- Disable:
  - Stimulus: en dropped mid-DWELL.
  - Response: IDLE next cycle, no tw_valid.
  - Stimulus: en dropped during OFFER.
  - Response: offer completes on tw_ready, then IDLE, busy = 0.
- Lock-up and edge dwell:
  - Stimulus: lfsr = 0 at the sample edge.
  - Response: tw_data = 32'h0100_0000; lock_err rises and stays high across later nonzero samples.
  - Stimulus: dwell = 0.
  - Response: period = 3 cycles with ready high.
- Wrap and reset:
  - Stimulus: BASE_TW = 32'hFFFF_0000, lfsr = 5'h1F.
  - Response: tw_data = 32'h001E_0000.
  - Stimulus: rst asserted during OFFER.
  - Response: tw_valid = 0 immediately; all outputs at reset values.
- Counter (HOP_CNT_EN):
  - Stimulus: 3 accepted hops.
  - Response: hop_count = 3.
  - Stimulus: preload hop_count to 16'hFFFF via force, then one more hop.
  - Response: hop_count = 0.
